// File: rtl/bitwise_lu_multicycle_pkg.sv
// Shared op-codes and FSM state encodings for the multicycle bitwise logic unit.
package bitwise_lu_multicycle_pkg;

  typedef enum logic [2:0] {
    LU_INV  = 3'd0,
    LU_AND  = 3'd1,
    LU_NAND = 3'd2,
    LU_OR   = 3'd3,
    LU_NOR  = 3'd4,
    LU_XOR  = 3'd5,
    LU_XNOR = 3'd6,
    LU_PASS = 3'd7
  } lu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lu_state_e;

endpackage

// File: rtl/bitwise_lu_multicycle_lu_slice.sv
// Combinational CHUNK-bit bitwise operation; one instance is shared across all slices.
module lu_slice
  import bitwise_lu_multicycle_pkg::*;
#(
  parameter int CHUNK = 16
) (
  input  logic [2:0]       i_op,
  input  logic [CHUNK-1:0] i_a,
  input  logic [CHUNK-1:0] i_b,
  output logic [CHUNK-1:0] o_y
);

  logic [CHUNK-1:0] w_and;
  logic [CHUNK-1:0] w_or;
  logic [CHUNK-1:0] w_xor;

  assign w_and = i_a & i_b;
  assign w_or  = i_a | i_b;
  assign w_xor = i_a ^ i_b;

  always_comb begin
    o_y = '0;
    case (lu_op_e'(i_op))
      LU_INV:  o_y = ~i_a;
      LU_AND:  o_y = w_and;
      LU_NAND: o_y = ~w_and;
      LU_OR:   o_y = w_or;
      LU_NOR:  o_y = ~w_or;
      LU_XOR:  o_y = w_xor;
      LU_XNOR: o_y = ~w_xor;
      LU_PASS: o_y = i_b;
      default: o_y = '0;
    endcase
  end

endmodule

// File: rtl/bitwise_lu_multicycle.sv
// Multicycle bitwise logic unit: applies one of eight ops to WIDTH-bit operands,
// CHUNK bits per cycle, with start/busy/done handshake and an all-zero flag.
module bitwise_lu_multicycle
  import bitwise_lu_multicycle_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_busy,
  output logic             o_done
);

  localparam int NSLICE = WIDTH / CHUNK;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_width
      $error("bitwise_lu_multicycle: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  lu_state_e        r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zacc;
  logic             r_zero;
  logic             r_busy;
  logic             r_done;

  logic [CHUNK-1:0] w_a_slice;
  logic [CHUNK-1:0] w_b_slice;
  logic [CHUNK-1:0] w_y_slice;
  logic             w_zacc_next;
  logic             w_last;

  // Single slice engine; operands are muxed by the slice counter
  assign w_a_slice   = r_a[r_cnt*CHUNK +: CHUNK];
  assign w_b_slice   = r_b[r_cnt*CHUNK +: CHUNK];
  assign w_zacc_next = r_zacc & (w_y_slice == '0);
  assign w_last      = (r_cnt == CW'(NSLICE - 1));

  lu_slice #(.CHUNK(CHUNK)) u_slice (
    .i_op (r_op),
    .i_a  (w_a_slice),
    .i_b  (w_b_slice),
    .o_y  (w_y_slice)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_zacc   <= 1'b1;
      r_zero   <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done <= 1'b0;
          if (i_start) begin
            r_op    <= i_op;
            r_a     <= i_a;
            r_b     <= i_b;
            r_cnt   <= '0;
            r_zacc  <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_result[r_cnt*CHUNK +: CHUNK] <= w_y_slice;
          r_zacc <= w_zacc_next;
          if (w_last) begin
            r_zero  <= w_zacc_next;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign o_result = r_result;
  assign o_zero   = r_zero;
  assign o_busy   = r_busy;
  assign o_done   = r_done;

endmodule

// File: tb/tb_bitwise_lu_multicycle.sv
// Bench for bitwise_lu_multicycle: transaction-level model plus directed vectors
// on the default 64/16 build, and spot checks on 32/32 and 8/2 builds.
module tb_bitwise_lu_multicycle;

  localparam bit [2:0] OP_INV = 3'd0, OP_AND = 3'd1, OP_NAND = 3'd2, OP_OR = 3'd3,
                       OP_NOR = 3'd4, OP_XOR = 3'd5, OP_XNOR = 3'd6, OP_PASS = 3'd7;
  localparam int NS64 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [2:0]  op    = '0;
  logic [63:0] a     = '0, b = '0;
  logic [63:0] result;
  logic        zero, busy, done;

  logic        s32_start = 1'b0;
  logic [2:0]  s32_op    = '0;
  logic [31:0] s32_a     = '0, s32_b = '0, s32_result;
  logic        s32_zero, s32_busy, s32_done;

  logic        s8_start = 1'b0;
  logic [2:0]  s8_op    = '0;
  logic [7:0]  s8_a     = '0, s8_b = '0, s8_result;
  logic        s8_zero, s8_busy, s8_done;

  bitwise_lu_multicycle dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op), .i_a(a), .i_b(b),
    .o_result(result), .o_zero(zero), .o_busy(busy), .o_done(done)
  );

  bitwise_lu_multicycle #(.WIDTH(32), .CHUNK(32)) dut32 (
    .i_clk(clk), .i_rst(rst), .i_start(s32_start), .i_op(s32_op), .i_a(s32_a), .i_b(s32_b),
    .o_result(s32_result), .o_zero(s32_zero), .o_busy(s32_busy), .o_done(s32_done)
  );

  bitwise_lu_multicycle #(.WIDTH(8), .CHUNK(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(s8_start), .i_op(s8_op), .i_a(s8_a), .i_b(s8_b),
    .o_result(s8_result), .o_zero(s8_zero), .o_busy(s8_busy), .o_done(s8_done)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_op(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    case (o)
      OP_INV:  return ~x;
      OP_AND:  return x & y;
      OP_NAND: return ~(x & y);
      OP_OR:   return x | y;
      OP_NOR:  return ~(x | y);
      OP_XOR:  return x ^ y;
      OP_XNOR: return ~(x ^ y);
      default: return y;
    endcase
  endfunction

  // Transaction model: an accepted request occupies the unit for NS64 cycles
  int          m_left   = 0;
  bit          m_done   = 1'b0;
  logic [63:0] m_pend   = '0;
  logic [63:0] m_result = '0;
  bit          m_zero   = 1'b1;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0; m_done = 1'b0; m_result = '0; m_zero = 1'b1;
    end else begin
      m_done = 1'b0;
      if (m_left == 0) begin
        if (start) begin
          m_pend = ref_op(op, a, b);
          m_left = NS64;
        end
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_done   = 1'b1;
          m_result = m_pend;
          m_zero   = (m_pend == '0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("model_busy", busy, m_left > 0);
      check("model_done", done, m_done);
      check("model_zero", zero, m_zero);
      if (m_left == 0) check("model_result", result, m_result);
    end
  end

  // Called at a negedge; start is sampled at the following posedge (E0)
  task automatic launch(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge just after E0; returns at the negedge where done is seen
  task automatic wait_done(output int lat, output int nbusy);
    lat = -1; nbusy = 0;
    if (busy) nbusy++;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin lat = k; break; end
    end
    if (lat < 0) begin
      n_checks++; n_errors++;
      $display("FAIL wait_done: timeout, done never seen");
    end
  endtask

  int lat, nb, ndone;
  logic [63:0] ra, rb;

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_result", result, 64'h0);
    check("rst_zero", zero, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    chk_en = 1'b1;

    // Reset mid-RUN
    launch(OP_XOR, 64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F);
    @(posedge clk); @(posedge clk);
    chk_en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_result", result, 64'h0);
    check("midrst_zero", zero, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done || busy) ndone++;
    end
    check("midrst_no_done", ndone, 0);
    chk_en = 1'b1;

    // XOR latency and busy window
    launch(OP_XOR, 64'hFFFF_0000_AAAA_5555, 64'h0F0F_0F0F_0F0F_0F0F);
    wait_done(lat, nb);
    check("xor_latency", lat, 4);
    check("xor_busy_cycles", nb, 4);
    check("xor_result", result, 64'hF0F0_0F0F_A5A5_5A5A);
    check("xor_zero", zero, 1'b0);
    @(negedge clk);
    check("xor_done_one_cycle", done, 1'b0);
    check("xor_result_held", result, 64'hF0F0_0F0F_A5A5_5A5A);

    // AND to zero, operands disturbed during RUN
    launch(OP_AND, 64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF);
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'hFFFF_FFFF_FFFF_FFFF; op = OP_OR;
    wait_done(lat, nb);
    check("and_result", result, 64'h0);
    check("and_zero", zero, 1'b1);

    // Start pulse while busy is ignored
    @(negedge clk);
    launch(OP_AND, 64'hF0F0_1234_FFFF_8001, 64'hFF00_FFFF_0F0F_8000);
    start = 1'b1; op = OP_NOR; a = 64'h0; b = 64'h0;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) begin
        ndone++;
        check("ignored_start_result", result, 64'hF000_1234_0F0F_8000);
      end
      @(negedge clk);
    end
    check("ignored_start_done_pulses", ndone, 1);
    check("ignored_start_zero", zero, 1'b0);

    // Back-to-back: start held during DONE
    launch(OP_OR, 64'h0, 64'h0);
    wait_done(lat, nb);
    check("b2b_first_zero", zero, 1'b1);
    launch(OP_INV, 64'h0, 64'h1234);
    check("b2b_reenter_busy", busy, 1'b1);
    wait_done(lat, nb);
    check("b2b_latency", lat, 4);
    check("b2b_result", result, 64'hFFFF_FFFF_FFFF_FFFF);
    check("b2b_zero", zero, 1'b0);

    // All eight ops on random operands, checked by the model
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      launch(3'(i), ra, rb);
      wait_done(lat, nb);
      check("rand_latency", lat, 4);
    end
    @(negedge clk);
    chk_en = 1'b0;

    // 32/32 build: single RUN cycle
    s32_op = OP_XNOR; s32_a = 32'h1234_5678; s32_b = 32'h1234_5678; s32_start = 1'b1;
    @(negedge clk);
    s32_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s32_done) begin lat = k; break; end
    end
    check("w32_latency", lat, 1);
    check("w32_result", {32'h0, s32_result}, 64'hFFFF_FFFF);
    check("w32_zero", s32_zero, 1'b0);

    // 8/2 build: four RUN cycles
    @(negedge clk);
    s8_op = OP_PASS; s8_a = 8'h5A; s8_b = 8'hC3; s8_start = 1'b1;
    @(negedge clk);
    s8_start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (s8_done) begin lat = k; break; end
    end
    check("w8_latency", lat, 4);
    check("w8_result", {56'h0, s8_result}, 64'hC3);
    check("w8_zero", s8_zero, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
